// File: rtl/uart_tx_if.sv
// Byte handshake between the packet layer and the UART transmitter.
// The master drives data/valid and the slave returns ready.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop serializer.
// Frames are sent back to back while the FIFO holds bytes.
module uart_tx #(
    parameter int CLK_PER_BIT = 868,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    uart_tx_if.slave                        bus,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(CLK_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic [2:0]           bit_cnt;
    logic [BW-1:0]        baud_cnt;

    logic push;
    logic pop;
    logic fifo_empty;
    logic bit_end;
    logic last_data;
    logic last_stop;

    assign bus.in_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign fifo_empty   = (fifo_count == '0);
    assign bit_end      = (baud_cnt == BW'(CLK_PER_BIT - 1));
    assign last_data    = (bit_cnt == 3'(DATA_BITS - 1));
    assign last_stop    = (bit_cnt == 3'(STOP_BITS - 1));

    // Pop on leaving IDLE or at the last stop-bit cycle so frames chain.
    assign pop = !fifo_empty &&
                 ((state == IDLE) ||
                  (state == STOP && bit_end && last_stop));

    // Circular byte buffer; a full FIFO refuses pushes regardless of pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame sequencer; tx and busy are registered so the line never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            shift    <= '0;
            par_bit  <= 1'b0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        par_bit <= (^mem[rd_ptr]) ^ 1'(PARITY_ODD);
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= shift[0];
                        shift    <= shift >> 1;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (last_data) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                tx    <= par_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (!last_stop) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (pop) begin
                            shift   <= mem[rd_ptr];
                            par_bit <= (^mem[rd_ptr]) ^ 1'(PARITY_ODD);
                            bit_cnt <= '0;
                            tx      <= 1'b0;
                            state   <= START;
                        end else begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1, even/odd parity, two stop bits,
// back-to-back frames, FIFO backpressure and asynchronous reset.
module tb_uart_tx;
    logic clk;
    logic rst;

    logic       vld [4];
    logic [7:0] dat [4];
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [3:0] rdy_v;
    logic [2:0] cnt_v [4];

    int errors;
    int checks;

    logic       cap_tx  [512];
    logic       cap_bz  [512];
    logic       cap_rdy [512];
    logic [2:0] cap_ct  [512];
    int         acc_cyc [8];

    uart_tx_if #(.DATA_BITS(8)) if0 ();
    uart_tx_if #(.DATA_BITS(8)) if1 ();
    uart_tx_if #(.DATA_BITS(8)) if2 ();
    uart_tx_if #(.DATA_BITS(8)) if3 ();

    assign if0.in_valid = vld[0];
    assign if0.in_data  = dat[0];
    assign if1.in_valid = vld[1];
    assign if1.in_data  = dat[1];
    assign if2.in_valid = vld[2];
    assign if2.in_data  = dat[2];
    assign if3.in_valid = vld[3];
    assign if3.in_data  = dat[3];
    assign rdy_v = {if3.in_ready, if2.in_ready, if1.in_ready, if0.in_ready};

    uart_tx #(
        .CLK_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0),
        .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave),
        .tx(tx_v[0]), .busy(busy_v[0]), .fifo_count(cnt_v[0])
    );

    uart_tx #(
        .CLK_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1),
        .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave),
        .tx(tx_v[1]), .busy(busy_v[1]), .fifo_count(cnt_v[1])
    );

    uart_tx #(
        .CLK_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1),
        .PARITY_ODD(1), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut2 (
        .clk(clk), .rst(rst), .bus(if2.slave),
        .tx(tx_v[2]), .busy(busy_v[2]), .fifo_count(cnt_v[2])
    );

    uart_tx #(
        .CLK_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0),
        .PARITY_ODD(0), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut3 (
        .clk(clk), .rst(rst), .bus(if3.slave),
        .tx(tx_v[3]), .busy(busy_v[3]), .fifo_count(cnt_v[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    // Expected line level during bit period b of a frame (4 clk per bit).
    function automatic logic exp_bit(input logic [7:0] d, input int pe,
                                     input int po, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pe != 0 && b == 9) return (^d) ^ po[0];
        return 1'b1;
    endfunction

    task automatic sample_now(input int sel, input int idx);
        cap_tx[idx]  = tx_v[sel];
        cap_bz[idx]  = busy_v[sel];
        cap_rdy[idx] = rdy_v[sel];
        cap_ct[idx]  = cnt_v[sel];
    endtask

    task automatic grab(input int sel, input int from, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_now(sel, from + i);
        end
    endtask

    task automatic chk_frame(input string tag, input int from,
                             input logic [7:0] d, input int pe,
                             input int po, input int ns);
        int n;
        int bad;
        int bz;
        n   = (1 + 8 + pe + ns) * 4;
        bad = 0;
        bz  = 0;
        for (int i = 0; i < n; i++) begin
            if (cap_tx[from+i] !== exp_bit(d, pe, po, i / 4)) bad++;
            if (cap_bz[from+i] === 1'b1) bz++;
        end
        chk({tag, "_bad_bits"}, bad, 0);
        chk({tag, "_busy_cycles"}, bz, n);
    endtask

    initial begin
        int nacc;
        int q;
        logic acc;
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vld[i] = 1'b0;
            dat[i] = 8'h00;
        end

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_tx", tx_v[0], 1);
        chk("rst_busy", busy_v[0], 0);
        chk("rst_count", cnt_v[0], 0);
        chk("rst_ready", rdy_v[0], 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0xA5, 8N1
        dat[0] = 8'hA5;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        chk("single_count_after_push", cnt_v[0], 1);
        chk("single_tx_before_pop", tx_v[0], 1);
        chk("single_busy_before_pop", busy_v[0], 0);
        grab(0, 0, 44);
        chk_frame("single", 0, 8'hA5, 0, 0, 1);
        chk("single_busy_end", cap_bz[40], 0);
        q = 0;
        for (int i = 40; i < 44; i++) if (cap_tx[i] !== 1'b1) q++;
        chk("single_idle_tx", q, 0);

        // Back-to-back 0x00, 0xFF, 0x55
        dat[0] = 8'h00;
        vld[0] = 1'b1;
        @(negedge clk);
        dat[0] = 8'hFF;
        @(negedge clk);
        sample_now(0, 0);
        dat[0] = 8'h55;
        @(negedge clk);
        sample_now(0, 1);
        vld[0] = 1'b0;
        grab(0, 2, 122);
        chk_frame("b2b_f0", 0, 8'h00, 0, 0, 1);
        chk_frame("b2b_f1", 40, 8'hFF, 0, 0, 1);
        chk_frame("b2b_f2", 80, 8'h55, 0, 0, 1);
        chk("b2b_count_s1", cap_ct[1], 2);
        chk("b2b_count_2nd_pop", cap_ct[40], 1);
        chk("b2b_count_3rd_pop", cap_ct[80], 0);
        chk("b2b_busy_end", cap_bz[120], 0);

        // Fill and backpressure
        dat[0] = 8'h01;
        vld[0] = 1'b1;
        nacc   = 0;
        for (int c = 0; c < 246; c++) begin
            acc = vld[0] && rdy_v[0];
            @(negedge clk);
            sample_now(0, c);
            if (acc) begin
                acc_cyc[nacc] = c;
                nacc++;
                if (nacc == 6) vld[0] = 1'b0;
                else dat[0] = 8'(nacc + 1);
            end
        end
        chk("fill_accepted", nacc, 6);
        chk("fill_acc4", acc_cyc[4], 4);
        chk("fill_acc5", acc_cyc[5], 42);
        chk("fill_count_full", cap_ct[4], 4);
        chk("fill_ready_low", cap_rdy[4], 0);
        chk("fill_count_after_pop", cap_ct[41], 3);
        for (int k = 0; k < 6; k++) begin
            chk_frame($sformatf("fill_f%0d", k), 1 + 40 * k,
                      8'(k + 1), 0, 0, 1);
        end
        chk("fill_busy_end", cap_bz[241], 0);

        // Even parity, 0x07
        dat[1] = 8'h07;
        vld[1] = 1'b1;
        @(negedge clk);
        vld[1] = 1'b0;
        grab(1, 0, 48);
        chk_frame("par_even", 0, 8'h07, 1, 0, 1);
        chk("par_even_bit", cap_tx[37], 1);
        chk("par_even_busy_end", cap_bz[44], 0);

        // Odd parity, 0x07
        dat[2] = 8'h07;
        vld[2] = 1'b1;
        @(negedge clk);
        vld[2] = 1'b0;
        grab(2, 0, 48);
        chk_frame("par_odd", 0, 8'h07, 1, 1, 1);
        chk("par_odd_bit", cap_tx[37], 0);
        chk("par_odd_busy_end", cap_bz[44], 0);

        // Two stop bits, 0x80
        dat[3] = 8'h80;
        vld[3] = 1'b1;
        @(negedge clk);
        vld[3] = 1'b0;
        grab(3, 0, 48);
        chk_frame("stop2", 0, 8'h80, 0, 0, 2);
        q = 0;
        for (int i = 36; i < 44; i++) if (cap_tx[i] === 1'b1) q++;
        chk("stop2_hold", q, 8);
        chk("stop2_busy_end", cap_bz[44], 0);

        // Reset mid-frame with two bytes queued
        dat[0] = 8'h00;
        vld[0] = 1'b1;
        @(negedge clk);
        dat[0] = 8'h11;
        @(negedge clk);
        dat[0] = 8'h22;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (16) @(negedge clk);
        chk("mid_tx_data3", tx_v[0], 0);
        chk("mid_count", cnt_v[0], 2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx", tx_v[0], 1);
        chk("mid_rst_busy", busy_v[0], 0);
        chk("mid_rst_count", cnt_v[0], 0);
        chk("mid_rst_ready", rdy_v[0], 1);
        @(negedge clk);
        rst = 1'b0;
        q = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) q++;
        end
        chk("post_rst_quiet", q, 0);
        dat[0] = 8'h3C;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        chk("post_rst_count", cnt_v[0], 1);
        grab(0, 0, 44);
        chk_frame("post_rst", 0, 8'h3C, 0, 0, 1);
        chk("post_rst_busy_end", cap_bz[40], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter for the interdevice controller, the transmit counterpart of the UART receiver on the same link. It accepts bytes from the packet layer over a valid/ready handshake and buffers them in a small FIFO. Each byte is serialized as an asynchronous frame on the `tx` line: start bit, LSB-first data, optional parity, stop bit(s). Line settings and baud divisor are compile-time and must match the peer receiver.

## Interface
- `CLK_PER_BIT`, 868: clk cycles per serial bit (100 MHz / 115200); legal ≥ 2.
- `DATA_BITS`, 8: data bits per frame; legal 5..8.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: with `PARITY_EN`=1, 0 selects even parity and 1 selects odd.
- `STOP_BITS`, 1: number of stop bits; legal 1 or 2.
- `FIFO_DEPTH`, 4: byte buffer entries; power of two, ≥ 2.
- `clk` in 1: system clock; everything is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_data` in `DATA_BITS`: byte to send.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the FIFO can accept a byte.
- `tx` out 1: serial line; registered output, idles high.
- `busy` out 1: a frame is in progress (any state other than IDLE).
- `fifo_count` out `$clog2(FIFO_DEPTH+1)`: number of entries currently in the FIFO.

## Operation
- Handshake: a byte is accepted at a rising edge where `in_valid && in_ready`.
  - `in_ready = (fifo_count != FIFO_DEPTH)`.
  - A full FIFO never accepts, even if a pop occurs in the same cycle.
  - `in_data` is ignored when the byte is not accepted.
- FIFO:
  - Circular buffer with read and write pointers; pointers wrap modulo `FIFO_DEPTH`.
  - A simultaneous push and pop leaves `fifo_count` unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter, and go to START.
  - START: `tx`=0 for `CLK_PER_BIT` cycles, then go to DATA.
  - DATA: `tx` = shift[0], shifted right each bit period. After `DATA_BITS` bit periods, go to PARITY if `PARITY_EN`, else STOP.
  - PARITY: `tx` = XOR of the data bits, XOR `PARITY_ODD`, for one bit period; then go to STOP.
  - STOP: `tx`=1 for `STOP_BITS` bit periods. On the last cycle of the last stop bit:
    - FIFO non-empty: pop and go directly to START, so there is no idle gap between frames.
    - FIFO empty: go to IDLE.
- Baud counter:
  - Counts 0..`CLK_PER_BIT`-1 and is reset to 0 on every state entry.
  - A bit period ends when the counter reaches `CLK_PER_BIT`-1.
- Parity is computed over the byte latched at pop, not over live `in_data`.
- Reset (async, any time, including mid-frame):
  - `tx`=1, `busy`=0, `fifo_count`=0, `in_ready`=1, FSM=IDLE.
  - FIFO pointers, shift register and counters are cleared.
  - Any partial frame is abandoned and FIFO contents are discarded.

## Timing
- Frame length: (1 + `DATA_BITS` + `PARITY_EN` + `STOP_BITS`) × `CLK_PER_BIT` cycles.
- Start latency from an empty, idle block:
  - The byte is accepted at edge N.
  - The pop occurs at edge N+1; `tx` falls and `busy` rises immediately after edge N+1.
- `fifo_count` updates on the edge of the push or pop. `in_ready` follows combinationally.
- Every `tx` transition coincides with a rising `clk` edge; there is no combinational path to `tx`.
- Back-to-back frames: the next start bit begins on the cycle immediately after the final stop-bit cycle.
- `busy` falls on the edge where STOP exits to IDLE.

## Test plan
- Single byte, `CLK_PER_BIT`=4, 8N1: push 0xA5.
  - `tx` = 0,1,0,1,0,0,1,0,1,1, each held exactly 4 cycles; start bit begins 1 cycle after acceptance.
  - `busy` is high for exactly 40 cycles, then `tx` stays 1.
- Back-to-back: push 0x00, 0xFF, 0x55 on consecutive cycles.
  - Three contiguous 40-cycle frames with no idle cycle between them; `fifo_count` reaches 0 at the third pop.
- Fill/backpressure, `FIFO_DEPTH`=4: hold `in_valid`=1 with data 0x01, 0x02, ….
  - 5 bytes are accepted (first popped immediately), then `in_ready`=0 and `fifo_count`=4.
  - The 6th byte is accepted on the edge after the pop at the end of frame 1.
  - Bytes are transmitted in order 0x01..0x06.
- Parity, `PARITY_EN`=1:
  - Even parity, 0x07: 11-bit frame with parity bit = 1.
  - `PARITY_ODD`=1, same byte: parity bit = 0.
- Two stop bits, `STOP_BITS`=2, 0x80: stop level held 8 cycles; frame is 44 cycles.
- Reset mid-frame: assert `rst` during data bit 3 with 2 bytes queued.
  - `tx`=1, `busy`=0 and `fifo_count`=0 take effect without waiting for a clock edge.
  - After release, `tx` stays 1 for 100 cycles with no push.
  - The next push transmits normally.
